// File: rtl/mbox_pkg.sv
// Shared types and sizing for the mailbox read buffer.
package mbox_pkg;

    localparam int RDBUF_DEPTH = 4;
    localparam int PTR_W       = 2;
    localparam int COUNT_W     = 3;

    // Bit 0 is the MSB of a 36-bit word.
    typedef logic [0:35]        word_t;
    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/par36.sv
// Odd-parity checker: 36 data bits plus one parity bit in, parity-good flag out.
module par36
    import mbox_pkg::*;
(
    input  word_t data_i,
    input  logic  par_i,
    output logic  odd_ok_o
);

    assign odd_ok_o = ^{data_i, par_i};

endmodule

// File: rtl/mbox_rdbuf.sv
// 4-entry show-ahead read buffer between memory return and the EDP AR mux.
// Optional per-entry parity when MBOX_RDBUF_PARITY_EN is defined.
module mbox_rdbuf
    import mbox_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         WR_VALID,
    input  word_t        WR_DATA,
`ifdef MBOX_RDBUF_PARITY_EN
    input  logic         PAR_IN,
`endif
    output logic         WR_READY,
    input  logic         RD_TAKE,
    output word_t        CACHE_DATA,
    output logic         DATA_VALID,
    output logic [2:0]   COUNT,
    output logic         OVERRUN,
    output logic         PAR_ERR
);

    word_t  mem_q [RDBUF_DEPTH];
    ptr_t   wptr_q, wptr_d;
    ptr_t   rptr_q, rptr_d;
    count_t count_q, count_d;
    logic   ovr_q, ovr_d;
    logic   push, pop;

    assign WR_READY   = (count_q < count_t'(RDBUF_DEPTH));
    assign DATA_VALID = (count_q != '0);
    assign COUNT      = count_q;
    assign OVERRUN    = ovr_q;
    assign CACHE_DATA = DATA_VALID ? mem_q[rptr_q] : '0;

    assign push = WR_VALID & WR_READY;
    assign pop  = RD_TAKE & DATA_VALID;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // A word offered while full is dropped; a same-cycle pop still happens.
        ovr_d   = ovr_q | (WR_VALID & ~WR_READY);
        if (push) wptr_d = wptr_q + ptr_t'(1);
        if (pop)  rptr_d = rptr_q + ptr_t'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    // Storage is not reset; stale entries are masked by COUNT.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= WR_DATA;
    end

`ifdef MBOX_RDBUF_PARITY_EN
    logic par_q [RDBUF_DEPTH];
    logic head_ok;

    always_ff @(posedge clk) begin
        if (push) par_q[wptr_q] <= PAR_IN;
    end

    par36 u_par36 (
        .data_i   (mem_q[rptr_q]),
        .par_i    (par_q[rptr_q]),
        .odd_ok_o (head_ok)
    );

    assign PAR_ERR = DATA_VALID & ~head_ok;
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mbox_rdbuf.sv
// Directed self-checking bench for mbox_rdbuf (parity steps when MBOX_RDBUF_PARITY_EN is defined).
module tb_mbox_rdbuf;
    import mbox_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       WR_VALID;
    word_t      WR_DATA;
    logic       WR_READY;
    logic       RD_TAKE;
    word_t      CACHE_DATA;
    logic       DATA_VALID;
    logic [2:0] COUNT;
    logic       OVERRUN;
    logic       PAR_ERR;
    logic       par_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mbox_rdbuf dut (
        .clk        (clk),
        .reset      (reset),
        .WR_VALID   (WR_VALID),
        .WR_DATA    (WR_DATA),
`ifdef MBOX_RDBUF_PARITY_EN
        .PAR_IN     (par_in),
`endif
        .WR_READY   (WR_READY),
        .RD_TAKE    (RD_TAKE),
        .CACHE_DATA (CACHE_DATA),
        .DATA_VALID (DATA_VALID),
        .COUNT      (COUNT),
        .OVERRUN    (OVERRUN),
        .PAR_ERR    (PAR_ERR)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [35:0] w, input logic p);
        WR_VALID = 1'b1;
        WR_DATA  = w;
        par_in   = p;
        tick();
        WR_VALID = 1'b0;
        par_in   = 1'b0;
    endtask

    task automatic pop();
        RD_TAKE = 1'b1;
        tick();
        RD_TAKE = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [35:0] data, input logic [2:0] cnt);
        check({tag, "_data"},  64'(CACHE_DATA), 64'(data));
        check({tag, "_count"}, 64'(COUNT),      64'(cnt));
        check({tag, "_dv"},    64'(DATA_VALID), 64'(cnt != 3'd0));
        check({tag, "_rdy"},   64'(WR_READY),   64'(cnt != 3'd4));
    endtask

    logic [35:0] fill [4];
    logic [35:0] refill [4];

    initial begin
        fill[0] = 36'h555555555; fill[1] = 36'h987654321;
        fill[2] = 36'hAAAAAAAAA; fill[3] = 36'o007757777;
        refill[0] = 36'h111111111; refill[1] = 36'h222222222;
        refill[2] = 36'h333333333; refill[3] = 36'h444444444;

        reset = 1'b1; WR_VALID = 1'b0; WR_DATA = '0; RD_TAKE = 1'b0; par_in = 1'b0;
        #1;
        check_state("rst", 36'h0, 3'd0);
        check("rst_ovr", 64'(OVERRUN), 64'd0);
        check("rst_par", 64'(PAR_ERR), 64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // single word
        push(36'h123456789, 1'b0);
        check_state("single_push", 36'h123456789, 3'd1);
        pop();
        check_state("single_pop", 36'h0, 3'd0);

        // fill and order
        for (int i = 0; i < 4; i++) push(fill[i], 1'b0);
        check_state("fill_full", fill[0], 3'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_order%0d", i), 64'(CACHE_DATA), 64'(fill[i]));
            pop();
        end
        check_state("fill_drained", 36'h0, 3'd0);
        check("no_ovr_yet", 64'(OVERRUN), 64'd0);

        // overrun with simultaneous pop
        for (int i = 0; i < 4; i++) push(refill[i], 1'b0);
        WR_VALID = 1'b1; WR_DATA = 36'hFFFFFFFFF; RD_TAKE = 1'b1;
        tick();
        WR_VALID = 1'b0; RD_TAKE = 1'b0;
        check_state("ovr_take", refill[1], 3'd3);
        check("ovr_set", 64'(OVERRUN), 64'd1);
        push(36'h555000555, 1'b0);
        check_state("ovr_refull", refill[1], 3'd4);
        // full write without pop must not disturb stored words
        push(36'hFFFFFFFFF, 1'b0);
        check_state("ovr_nochange", refill[1], 3'd4);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("ovr_order%0d", i), 64'(CACHE_DATA), 64'(refill[i]));
            pop();
        end
        check("ovr_last", 64'(CACHE_DATA), 64'h555000555);
        pop();
        check_state("ovr_drained", 36'h0, 3'd0);
        repeat (10) tick();
        check("ovr_sticky", 64'(OVERRUN), 64'd1);

        // wrap and concurrency at COUNT=2
        push(36'h100, 1'b0);
        push(36'h101, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_head%0d", i), 64'(CACHE_DATA), 64'(36'h100 + 36'(i)));
            WR_VALID = 1'b1; WR_DATA = 36'h102 + 36'(i); RD_TAKE = 1'b1;
            tick();
            WR_VALID = 1'b0; RD_TAKE = 1'b0;
            check($sformatf("wrap_cnt%0d", i), 64'(COUNT), 64'd2);
        end
        check("wrap_tail0", 64'(CACHE_DATA), 64'h108);
        pop();
        check("wrap_tail1", 64'(CACHE_DATA), 64'h109);
        pop();
        check_state("wrap_drained", 36'h0, 3'd0);

        // underrun ignored
        pop();
        check_state("underrun", 36'h0, 3'd0);
        push(36'hABC, 1'b0);
        check_state("after_underrun", 36'hABC, 3'd1);

        // asynchronous reset mid-cycle at COUNT=3
        push(36'hDEF, 1'b0);
        push(36'h321, 1'b0);
        check_state("pre_reset", 36'hABC, 3'd3);
        #3 reset = 1'b1;
        #1;
        check_state("async_rst", 36'h0, 3'd0);
        check("async_rst_ovr", 64'(OVERRUN), 64'd0);
        check("async_rst_par", 64'(PAR_ERR), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check_state("post_reset", 36'h0, 3'd0);

`ifdef MBOX_RDBUF_PARITY_EN
        push(36'h000000001, 1'b0);
        check("par_good", 64'(PAR_ERR), 64'd0);
        push(36'h000000001, 1'b1);
        check("par_head_good", 64'(PAR_ERR), 64'd0);
        pop();
        check("par_bad", 64'(PAR_ERR), 64'd1);
        check("par_bad_data", 64'(CACHE_DATA), 64'h1);
        pop();
        check("par_empty", 64'(PAR_ERR), 64'd0);
`else
        push(36'h000000001, 1'b1);
        check("par_tied", 64'(PAR_ERR), 64'd0);
        pop();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mbox_rdbuf.md
MBOX_RDBUF -- requirements
Module: mbox_rdbuf

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL provide ports exactly as follows:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- WR_VALID  in  1  memory-return word offered this cycle.
- WR_DATA  in  36 [0:35]  memory-return word; bit 0 is MSB.
- WR_READY  out  1  buffer can accept a word this cycle.
- RD_TAKE  in  1  EBOX consumes head word (AR load with AR/CACHE selected).
- CACHE_DATA  out  36 [0:35]  head word presented to the EDP AR mux.
- DATA_VALID  out  1  CACHE_DATA holds a valid word.
- COUNT  out  3  occupancy, 0..4.
- OVERRUN  out  1  sticky: a word was offered while the buffer was full.
- PAR_IN  in  1  odd parity for WR_DATA; present only with the macro.
- PAR_ERR  out  1  head word fails odd parity.

Function
REQ-003 SHALL be a 4-entry FIFO of 36-bit words with show-ahead read.
REQ-004 Push: SHALL accept a word when WR_VALID & WR_READY.
REQ-005 Pop: SHALL remove the head word when RD_TAKE & DATA_VALID.
REQ-006 WR_READY SHALL equal (COUNT<4), combinational from registered COUNT.
REQ-007 DATA_VALID SHALL equal (COUNT!=0).
REQ-008 CACHE_DATA SHALL be the head word when DATA_VALID, else 36'o0.
REQ-009 Latency: a word pushed at edge N into an empty buffer SHALL appear on CACHE_DATA with DATA_VALID=1 after edge N. No same-cycle bypass.
REQ-010 Write and read pointers SHALL be 2 bits and wrap 3->0.
REQ-011 Simultaneous push and pop with 1<=COUNT<=3: COUNT unchanged, both pointers advance.
REQ-012 Full buffer (COUNT=4) with WR_VALID=1:
- word dropped and OVERRUN set, even if RD_TAKE=1 in the same cycle;
- the pop still occurs.
REQ-013 RD_TAKE while empty SHALL be ignored: no pointer or COUNT change, no flag.
REQ-014 WR_VALID with WR_READY=0 SHALL NOT corrupt any stored entry.
REQ-015 OVERRUN SHALL remain 1 until reset.

Reset
REQ-016 Reset SHALL force COUNT=0, both pointers=0, OVERRUN=0.
REQ-017 Consequent outputs during and after reset: DATA_VALID=0, CACHE_DATA=0, WR_READY=1, PAR_ERR=0.
REQ-018 Reset asserted mid-operation SHALL discard all stored words immediately (asynchronous).
REQ-019 Storage array contents need not be cleared by reset; they SHALL be masked by COUNT.

Configuration
REQ-020 Macro MBOX_RDBUF_PARITY_EN defined:
- PAR_IN port exists and is stored per entry alongside its word;
- PAR_ERR = DATA_VALID & ~(XOR of head data bits 0..35 and stored parity bit);
- PAR_ERR is combinational on the head entry;
- PAR_ERR does not block RD_TAKE.
REQ-021 MBOX_RDBUF_PARITY_EN undefined:
- PAR_IN port absent;
- PAR_ERR tied 0;
- no parity storage.

Structure
REQ-022 Shared package mbox_pkg SHALL hold:
- the 36-bit word typedef (bits [0:35]);
- the RDBUF_DEPTH=4 constant;
- the pointer width constant.
REQ-023 Parity evaluation SHALL be one sub-module, par36: 36 data bits plus parity bit in, odd-parity-good flag out.
REQ-024 The FIFO control (pointers, COUNT, flags) SHALL reside in mbox_rdbuf itself.

Verification
REQ-025 Single word: push 36'h123456789 into empty buffer -> next cycle CACHE_DATA=36'h123456789, DATA_VALID=1, COUNT=1; RD_TAKE one cycle -> COUNT=0, CACHE_DATA=0.
REQ-026 Fill and order: push 36'h555555555, 36'h987654321, 36'hAAAAAAAAA, 36'o007757777 -> COUNT=4, WR_READY=0; four pops return the words in that order.
REQ-027 Overrun: with buffer full, WR_VALID=1 with RD_TAKE=1 and data 36'hFFFFFFFFF -> word dropped, OVERRUN=1, COUNT=3; OVERRUN stays 1 through 10 further idle cycles.
REQ-028 Wrap and concurrency: hold COUNT=2 and push+pop every cycle for 8 cycles with incrementing data -> COUNT stays 2, pops strictly in order across pointer wrap.
REQ-029 Underrun and reset: RD_TAKE while empty -> no change; reset asserted at COUNT=3 between clock edges -> DATA_VALID=0 and COUNT=0 without waiting for a clock edge.
REQ-030 Parity (macro defined): push 36'h000000001 with PAR_IN=0 -> PAR_ERR=0; push 36'h000000001 with PAR_IN=1 -> PAR_ERR=1 when that word is at the head.
